// File: rtl/mux8_arb_pkg.sv
// mux8_arb_pkg: shared types and sizes for the mux8 round-robin arbiter
package mux8_arb_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 8;
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: first set bit of v searching upward from p, wrapping 7->0
module rr_pick8
    import mux8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] v,
    input  logic [SEL_W-1:0] p,
    output logic [SEL_W-1:0] idx,
    output logic             any
);
    logic [2*N_REQ-1:0] vv;
    assign vv  = {v, v} >> p;
    assign any = |v;
    always_comb begin
        idx = p;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (vv[k]) idx = p + SEL_W'(k);
    end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: burst-limited round-robin owner of the 8:1 select; MUX8_ARB_LOCK_EN adds lock
module mux8_rr_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int BURST = 4,
    parameter int CNT_W = mux8_arb_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] d,
`ifdef MUX8_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             y
);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [SEL_W-1:0] ptr, ptr_n, sel_n, pick_p, pick_idx;
    logic [N_REQ-1:0] gnt_n;
    logic lock_eff, pick_any, rel, hold;
`ifdef MUX8_ARB_LOCK_EN
    assign lock_eff = lock;
`else
    assign lock_eff = 1'b0;
`endif
    // after a release ptr equals sel+1, so one pick instance covers both paths
    assign pick_p = (state == BUSY) ? sel + 1'b1 : ptr;
    rr_pick8 u_pick (.v(req), .p(pick_p), .idx(pick_idx), .any(pick_any));
    assign y = valid & d[sel];
    always_comb begin
        rel     = !req[sel] || (cnt == CNT_W'(BURST) && !lock_eff);
        hold    = (state == BUSY) && !rel;
        state_n = (hold || pick_any) ? BUSY : IDLE;
        sel_n   = hold ? sel : (pick_any ? pick_idx : '0);
        cnt_n   = hold ? ((cnt == CNT_W'(BURST)) ? cnt : cnt + 1'b1) : (pick_any ? CNT_W'(1) : '0);
        ptr_n   = (state == BUSY && rel) ? sel + 1'b1 : ptr;
        gnt_n   = (state_n == BUSY) ? N_REQ'(1) << sel_n : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            sel   <= '0;
            gnt   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            gnt   <= gnt_n;
            valid <= (state_n == BUSY);
        end
    end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: directed self-checking bench for mux8_rr_arbiter (BURST = 4)
module tb_mux8_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] req, d, gnt;
    logic [2:0] sel;
    logic valid, y, lock;
    int tests = 0;
    int fails = 0;

    mux8_rr_arbiter #(.BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .d(d),
`ifdef MUX8_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt), .sel(sel), .valid(valid), .y(y)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] s, input logic v);
        chk({tag, " sel"}, 8'(sel), 8'(v ? s : 3'd0));
        chk({tag, " gnt"}, gnt, v ? 8'(8'd1 << s) : 8'h00);
        chk({tag, " valid"}, 8'(valid), 8'(v));
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; d = 8'h00; lock = 1'b0;
        step(); step();
        chk_out("reset", 3'd0, 1'b0);
        chk("reset y", 8'(y), 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk_out("idle", 3'd0, 1'b0);
            chk("idle y", 8'(y), 8'h00);
        end
        // single requester: burst expiry regrants it without a gap
        req = 8'h01;
        step();
        chk_out("first grant", 3'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            d = {7'h55, i[0]};
            #1;
            chk("y tracks d0", 8'(y), 8'(i[0]));
            chk_out("sole owner", 3'd0, 1'b1);
            step();
        end
        rst = 1'b1; req = 8'h00;
        step();
        rst = 1'b0;
        step();
        // full contention: rotate 0..7, 4 cycles each
        req = 8'hFF; d = 8'h00;
        step();
        for (int k = 0; k < 36; k++) begin
            chk_out("rotate", 3'((k / 4) % 8), 1'b1);
            step();
        end
        rst = 1'b1;
        step();
        chk_out("mid reset", 3'd0, 1'b0);
        chk("mid reset y", 8'(y), 8'h00);
        rst = 1'b0;
        step();
        chk_out("post reset", 3'd0, 1'b1);
        // two requesters, owner drops early
        rst = 1'b1; req = 8'h00;
        step();
        rst = 1'b0; req = 8'h24;
        step();
        chk_out("req24 grant", 3'd2, 1'b1);
        step();
        req = 8'h20;
        step();
        chk_out("drop handover", 3'd5, 1'b1);
        req = 8'h01;
        step();
        chk_out("same-cycle new req", 3'd0, 1'b1);
        req = 8'h00;
        step();
        chk_out("to idle", 3'd0, 1'b0);
`ifdef MUX8_ARB_LOCK_EN
        rst = 1'b1;
        step();
        rst = 1'b0; lock = 1'b1; req = 8'h81;
        step();
        for (int i = 0; i < 12; i++) begin
            chk_out("locked", 3'd0, 1'b1);
            step();
        end
        lock = 1'b0;
        step();
        chk_out("unlock", 3'd7, 1'b1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer for the shared 8-to-1, 1-bit selection datapath. Eight requesters compete for the single output line; the block grants one requester at a time, drives the 3-bit select code, and forwards the granted requester's data bit. Grants are bounded by a burst limit so no requester can starve the others. It sits directly in front of the 8:1 selection stage and owns its select lines.

## Interface
Parameters:
- BURST, 4, maximum consecutive grant cycles per owner; legal range 1..255.
- CNT_W, 8, burst counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- req  in  8  per-requester request; level, held while data is valid.
- d  in  8  per-requester data bit; d[i] belongs to requester i.
- lock  in  1  owner asks to extend its burst; present only under MUX8_ARB_LOCK_EN.
- gnt  out  8  one-hot grant, registered; all-zero when idle.
- sel  out  3  binary index of the owner, registered; drives the 8:1 select.
- valid  out  1  high while a grant is active.
- y  out  1  d[sel] when valid, else 0; combinational from registered sel.

## Operation
- FSM states:
  - IDLE: no owner.
  - BUSY: one owner, index o held in sel.
- pick(v, p): the first set bit of v, searching upward from index p with wrap 7→0. Used for every grant decision.
- Round-robin pointer ptr, 3 bits:
  - Reset value 0.
  - Set to o+1 mod 8 whenever the owner's grant ends.
- IDLE:
  - If req != 0: at the edge, grant pick(req, ptr), go to BUSY, cnt ← 1.
  - Otherwise stay in IDLE.
- BUSY, with release condition R = !req[o] OR (cnt == BURST AND NOT lock_eff):
  - If R is false: cnt ← cnt+1, saturating at BURST; owner unchanged.
  - If R is true: ptr ← o+1.
    - If req != 0: regrant pick(req, o+1) at the same edge, cnt ← 1. There is zero idle gap between back-to-back owners.
    - If req == 0: go to IDLE, gnt ← 0, valid ← 0.
- Burst expiry with the owner as the sole requester: pick wraps to o, so the owner is regranted with cnt ← 1 and valid stays high.
- gnt, sel and valid always agree: gnt == (1 << sel) whenever valid; gnt == 0 when !valid.
- Reset values: state IDLE, gnt 0, sel 0, valid 0, cnt 0, ptr 0; y therefore 0.
- Reset asserted mid-grant: all of the above take effect at the next edge regardless of req or lock.

## Timing
- Grant latency: req sampled at edge N produces gnt/sel/valid after edge N. There is one cycle from the first req cycle to the grant.
- Release latency: the owner dropping req in cycle N is seen at edge N+1, and the new owner is visible after edge N+1.
- A requester asserting req in the same cycle the owner drops is eligible at that same edge.
- y follows d combinationally during a grant, with no added latency.
- Maximum wait for any continuously requesting input: 7 × BURST cycles plus 1, with lock disabled.

## Configuration
- MUX8_ARB_LOCK_EN defined:
  - lock port present; lock_eff = lock.
  - While lock = 1 and req[o] = 1, the owner is kept past BURST, with cnt saturated at BURST.
  - Dropping req still releases the grant.
- MUX8_ARB_LOCK_EN undefined:
  - No lock port; lock_eff = 0.
  - Grants end strictly at BURST cycles.

## Structure
- Shared package mux8_arb_pkg holds:
  - the state typedef (IDLE, BUSY);
  - N_REQ = 8 and SEL_W = 3;
  - the CNT_W default.
- One sub-module, rr_pick8: combinational rotate-priority find-first.
  - Inputs: v[7:0] and p[2:0].
  - Outputs: idx[2:0] and any.
- Both grant paths (from IDLE and on release in BUSY) use the single rr_pick8 instance.

## Test plan
- Reset, then req = 8'h00 for 10 cycles → gnt 0, sel 0, valid 0, y 0 throughout.
- req = 8'h01 from cycle 0, d[0] toggling → gnt 8'h01 after edge 1; y tracks d[0]; BURST = 4 expiry regrants requester 0 with valid never dropping.
- req = 8'hFF held, BURST = 4 → grants rotate 0,1,2,…,7,0, each exactly 4 cycles, sel incrementing with wrap.
- req = 8'h24 (requesters 2 and 5), owner 2 drops req at cycle 6 → sel = 5 after edge 7; no idle cycle; ptr = 3.
- rst pulsed for 1 cycle mid-grant with req = 8'hFF → all outputs 0 after that edge; the next grant goes to requester 0.
- MUX8_ARB_LOCK_EN with lock = 1 and req = 8'h81, owner 0 → requester 0 holds for 12 cycles; lock cleared → sel = 7 after the next edge.
